// File: rtl/split_port_responder.sv
// Arbitrates CPU instruction (a) and data (b) ports onto one word memory; strobe 1 cycle after grant, resp 1 cycle after mem_resp.
// Requests are held by the CPU until resp (no backpressure beyond that); SPLIT_PORT_RR_EN selects round-robin, else port b wins ties.
module split_port_responder #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  output logic                  resp_a,
  output logic [31:0]           rdata_a,
  input  logic                  read_b,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wmask,
  output logic                  resp_b,
  output logic [31:0]           rdata_b,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  port_b_q, port_b_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           rdata_a_q, rdata_a_d;
  logic [31:0]           rdata_b_q, rdata_b_d;

  logic req_a, req_b, grant_b, tie_to_b;

  // The memory is word-addressed; byte offsets are dropped at grant.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{address_a[1:0], address_b[1:0]};

  assign req_a = read_a;
  assign req_b = read_b | write;

`ifdef SPLIT_PORT_RR_EN
  logic last_b_q, last_b_d;

  assign tie_to_b = ~last_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == IDLE && (req_a || req_b)) begin
      last_b_d = grant_b;
    end
  end
`else
  assign tie_to_b = 1'b1;
`endif

  assign grant_b = req_b & (~req_a | tie_to_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      port_b_q  <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      port_b_q  <= port_b_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_b_d  = port_b_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    resp_a    = 1'b0;
    resp_b    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          if (grant_b) begin
            addr_d   = {address_b[ADDR_WIDTH-1:2], 2'b00};
            wdata_d  = wdata;
            wmask_d  = wmask;
            op_wr_d  = write;
            port_b_d = 1'b1;
            state_d  = BUSY_B;
          end else begin
            addr_d   = {address_a[ADDR_WIDTH-1:2], 2'b00};
            op_wr_d  = 1'b0;
            port_b_d = 1'b0;
            state_d  = BUSY_A;
          end
        end
      end
      BUSY_A: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          rdata_a_d = mem_rdata;
          state_d   = RESP;
        end
      end
      BUSY_B: begin
        mem_read  = ~op_wr_q;
        mem_write = op_wr_q;
        if (mem_resp) begin
          if (!op_wr_q) begin
            rdata_b_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        // Dead cycle so a request retiring on this edge is not re-granted.
        resp_a  = ~port_b_q;
        resp_b  = port_b_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign rdata_a     = rdata_a_q;
  assign rdata_b     = rdata_b_q;

endmodule

// File: tb/tb_split_port_responder.sv
// Directed, table-driven bench for split_port_responder plus arbitration and mid-transaction reset sequences.
module tb_split_port_responder;

  logic        clk;
  logic        rst_n;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b;
  logic        write;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        rd_a;
    logic        rd_b;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  wmsk;
    int          waits;
    logic [31:0] mdata;
    logic        exp_b;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_ra;
    logic [31:0] exp_rb;
  } vec_t;

  vec_t vecs[5];
  vec_t post_rst;
  logic [31:0] arb_exp[4];

  split_port_responder #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_a      (read_a),
    .address_a   (address_a),
    .resp_a      (resp_a),
    .rdata_a     (rdata_a),
    .read_b      (read_b),
    .write       (write),
    .address_b   (address_b),
    .wdata       (wdata),
    .wmask       (wmask),
    .resp_b      (resp_b),
    .rdata_b     (rdata_b),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    read_a    = 1'b0;
    read_b    = 1'b0;
    write     = 1'b0;
    address_a = 32'h0;
    address_b = 32'h0;
    wdata     = 32'h0;
    wmask     = 4'h0;
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic apply_vec(input vec_t v);
    read_a    = v.rd_a;
    read_b    = v.rd_b;
    write     = v.wr;
    address_a = v.rd_a ? v.addr : 32'hFFFF_FFF0;
    address_b = v.rd_a ? 32'h0BAD_0000 : v.addr;
    wdata     = v.wdat;
    wmask     = v.wmsk;
    @(posedge clk);
    @(negedge clk);
    for (int w = 0; w <= v.waits; w++) begin
      chk1("busy_mem_read", mem_read, ~v.exp_wr);
      chk1("busy_mem_write", mem_write, v.exp_wr);
      chk32("busy_mem_address", mem_address, v.exp_addr);
      if (v.exp_wr) begin
        chk32("busy_mem_wdata", mem_wdata, v.wdat);
        chk32("busy_mem_wmask", {28'h0, mem_wmask}, {28'h0, v.wmsk});
      end
      chk1("busy_no_resp", resp_a | resp_b, 1'b0);
      mem_resp  = (w == v.waits);
      mem_rdata = (w == v.waits) ? v.mdata : 32'h5A5A_5A5A;
      @(posedge clk);
      @(negedge clk);
    end
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    chk1("resp_a_pulse", resp_a, ~v.exp_b);
    chk1("resp_b_pulse", resp_b, v.exp_b);
    chk1("resp_strobes_low", mem_read | mem_write, 1'b0);
    chk32("resp_rdata_a", rdata_a, v.exp_ra);
    chk32("resp_rdata_b", rdata_b, v.exp_rb);
    read_a = 1'b0;
    read_b = 1'b0;
    write  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("after_resp_a_low", resp_a, 1'b0);
    chk1("after_resp_b_low", resp_b, 1'b0);
    chk1("after_strobes_low", mem_read | mem_write, 1'b0);
    chk32("hold_rdata_a", rdata_a, v.exp_ra);
    chk32("hold_rdata_b", rdata_b, v.exp_rb);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    //          rd_a  rd_b  wr    addr          wdata         wmask  waits mdata         exp_b exp_wr exp_addr      exp_ra        exp_rb
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0,        4'h0,  0, 32'h0000_0013, 1'b0, 1'b0, 32'h0000_0060, 32'h0000_0013, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_1003, 32'hAB00_0000, 4'h8, 3, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0013, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2006, 32'h0,        4'h0,  1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_2004, 32'h0000_0013, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, 0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0013, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_007F, 32'h0,        4'h0,  2, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_007C, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    post_rst = '{1'b1, 1'b0, 1'b0, 32'h0000_0061, 32'h0,       4'h0,  0, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0060, 32'h0000_0055, 32'h0};

    // Reset values, checked while reset is still asserted.
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk1("rst_resp_a", resp_a, 1'b0);
    chk1("rst_resp_b", resp_b, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_rdata_a", rdata_a, 32'h0);
    chk32("rst_rdata_b", rdata_b, 32'h0);
    chk32("rst_mem_address", mem_address, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      apply_vec(vecs[i]);
    end

    // Both ports requesting continuously from a fresh reset.
`ifdef SPLIT_PORT_RR_EN
    arb_exp = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0200, 32'h0000_0100};
`else
    arb_exp = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200};
`endif
    do_reset();
    read_a    = 1'b1;
    read_b    = 1'b1;
    address_a = 32'h0000_0100;
    address_b = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk32("arb_grant_addr", mem_address, arb_exp[k]);
      chk1("arb_mem_read", mem_read, 1'b1);
      mem_resp  = 1'b1;
      mem_rdata = 32'hA000_0000 + k;
      @(posedge clk);
      @(negedge clk);
      mem_resp = 1'b0;
      chk1("arb_resp_b", resp_b, arb_exp[k] == 32'h0000_0200);
      chk1("arb_resp_a", resp_a, arb_exp[k] == 32'h0000_0100);
      @(posedge clk);
      @(negedge clk);
      chk1("arb_idle_strobe", mem_read, 1'b0);
    end
    idle_inputs();
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of a BUSY_B read, then a stray mem_resp in IDLE.
    do_reset();
    read_b    = 1'b1;
    address_b = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    chk1("midrst_busy_read", mem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_mem_read_drop", mem_read, 1'b0);
    chk1("midrst_mem_write_drop", mem_write, 1'b0);
    chk1("midrst_resp_b_low", resp_b, 1'b0);
    read_b = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk1("midrst_no_resp_b", resp_b, 1'b0);
      chk1("midrst_idle_read", mem_read, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    chk32("midrst_rdata_b", rdata_b, 32'h0);
    apply_vec(post_rst);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/split_port_responder.md
# split_port_responder

Memory-side responder for the CPU's split instruction (port a) and data (port b) request interfaces. It arbitrates both ports onto one single-ported word memory and returns a one-cycle `resp_a`/`resp_b` pulse with read data. It sits between the pipelined datapath and the cache/physical memory.

## Interface
- `ADDR_WIDTH`, 32, byte-address width on all ports.
- `clk` input 1: the block's single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `read_a` input 1: instruction read request; held until `resp_a`.
- `address_a` input ADDR_WIDTH: instruction byte address.
- `resp_a` output 1: one-cycle completion pulse for port a.
- `rdata_a` output 32: instruction word; valid while `resp_a`=1, then held.
- `read_b` input 1: data read request.
- `write` input 1: data write request.
- `address_b` input ADDR_WIDTH: data byte address.
- `wdata` input 32: write data.
- `wmask` input 4: byte enables.
- `resp_b` output 1: one-cycle completion pulse for port b (read or write).
- `rdata_b` output 32: data read word; valid while `resp_b`=1, then held.
- `mem_read` output 1: downstream read strobe.
- `mem_write` output 1: downstream write strobe.
- `mem_address` output ADDR_WIDTH: word-aligned downstream address.
- `mem_wdata` output 32: downstream write data.
- `mem_wmask` output 4: downstream byte enables.
- `mem_resp` input 1: downstream completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: downstream read data.

## Operation
- The FSM has four states: IDLE, BUSY_A, BUSY_B and RESP. Reset enters IDLE.
- **IDLE**
  - Samples the requests. A port b request is `read_b|write`.
  - If exactly one port requests, that port is granted.
  - If both request, arbitration per Configuration decides.
  - On grant, the block registers the address with bits [1:0] forced to 0. For port b it also registers `wdata`, `wmask` and op (write=1 if `write`).
  - The FSM then moves to BUSY_A or BUSY_B.
  - With no request, the FSM stays in IDLE.
- **BUSY_x**
  - `mem_read` or `mem_write` is asserted from state and registered op; registered address and data drive the `mem_*` outputs.
  - The state holds until `mem_resp`=1.
  - If `read_b` and `write` are both high at grant, the transaction is a write.
  - On `mem_resp`, read transactions capture `mem_rdata` into `rdata_a` or `rdata_b`, and the FSM goes to RESP.
- **RESP**
  - Exactly one of `resp_a`/`resp_b` is 1, matching the granted port.
  - The FSM returns to IDLE unconditionally. This dead cycle prevents re-granting a request the CPU is retiring on this edge.
- Writes never modify `rdata_b`. `rdata_a`/`rdata_b` change only on a read capture.
- `mem_read` and `mem_write` are never both 1. Both are 0 outside BUSY.
- Requests that change or drop during BUSY/RESP are ignored, since the registered copy is used. The CPU protocol forbids this case.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `resp_a`, `resp_b`, `mem_read`, `mem_write` = 0.
  - `rdata_a`, `rdata_b`, `mem_address`, `mem_wdata` = 0; `mem_wmask` = 0.
  - Last-grant register = port a.
- Latency:
  - A request seen in IDLE at cycle 0 produces a mem strobe in cycle 1.
  - With `mem_resp` in cycle 1, the resp pulse occurs in cycle 2.
  - Each downstream wait cycle adds one cycle.
- Throughput: at most one transaction per 3 cycles (IDLE, BUSY, RESP).
- Reset asserted mid-BUSY abandons the downstream transaction; strobes drop immediately. A `mem_resp` arriving after reset release while in IDLE is ignored.
- `mem_resp` in IDLE or RESP is ignored.

## Configuration
- `SPLIT_PORT_RR_EN`
  - Defined: round-robin. On simultaneous requests, the port not granted last wins. The last-grant register updates on every grant.
  - Undefined: fixed priority. Port b always wins ties, and the last-grant register is absent. Port a can starve under continuous port b traffic; this is accepted because the CPU stalls on b.

## Test plan
- Reset, then `read_a`=1 with `address_a`=0x60 and zero-wait memory returning 0x00000013.
  - Required: `mem_read`=1 with `mem_address`=0x60 in cycle 1.
  - Required: `resp_a` pulses in cycle 2 with `rdata_a`=0x00000013; `rdata_a` holds afterwards.
- `write`=1, `address_b`=0x1003, `wdata`=0xAB000000, `wmask`=4'b1000, with `mem_resp` after 3 wait cycles.
  - Required: `mem_write`=1 and `mem_address`=0x1000 for 4 cycles.
  - Required: `resp_b` pulses once and `rdata_b` is unchanged.
- Both ports request continuously with the macro defined.
  - Required: grants alternate b, a, b, a…, starting with b after reset (last = a).
- Both ports request continuously with the macro undefined.
  - Required: only port b is ever granted.
- Assert `rst_n`=0 in the middle of a BUSY_B read.
  - Required: strobes and resp go to 0 immediately and no `resp_b` follows.
  - Required: a later `read_a` completes normally.
- `read_b` and `write` both 1.
  - Required: `mem_write` (not `mem_read`) is issued, `resp_b` pulses, and `rdata_b` is unchanged.
